alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/alu_decode.sv | 56 +++++
 rtl/alu_exec_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: control codes, alu_op encodings, FSM states.
// Also hosts the funct3 -> base-op helper used by decode.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MUL  = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    AOP_LDST  = 2'b00,
    AOP_BR    = 2'b01,
    AOP_RTYPE = 2'b10,
    AOP_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_BUSY,
    S_DONE
  } state_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  function automatic alu_ctrl_e base_op(
    input logic [2:0] f3
  );
    alu_ctrl_e op;
    op = ALU_ADD;
    unique case (f3)
      3'b000: op = ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between issue logic and the ALU.
// master = requester, slave = execution unit.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [9:0]      ins_for_alu;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      alu_control;
  logic            illegal;

  modport master (
    output in_valid, alu_op, ins_for_alu,
    output op_a, op_b, out_ready,
    input  in_ready, out_valid, result,
    input  zero, alu_control, illegal
  );

  modport slave (
    input  in_valid, alu_op, ins_for_alu,
    input  op_a, op_b, out_ready,
    output in_ready, out_valid, result,
    output zero, alu_control, illegal
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational alu_op/funct decode to a 4-bit ALU control code.
// Undefined R-type encodings fall back to ADD and flag illegal.
module alu_decode
  import alu_pkg::*;
#(
  parameter int MUL_EN = 1
) (
  input  logic [1:0] alu_op,
  input  logic [9:0] ins_for_alu,
  output alu_ctrl_e  code,
  output logic       illegal
);

  logic [6:0] f7;
  logic [2:0] f3;

  assign f7 = ins_for_alu[9:3];
  assign f3 = ins_for_alu[2:0];

  // map the encoding to an op and flag undefined ones
  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    unique case (alu_op_e'(alu_op))
      AOP_LDST: code = ALU_ADD;
      AOP_BR:   code = ALU_SUB;
      AOP_RTYPE: begin
        unique case (1'b1)
          (f7 == F7_BASE):
            code = base_op(f3);
          (f7 == F7_ALT) && (f3 == 3'b000):
            code = ALU_SUB;
          (f7 == F7_ALT) && (f3 == 3'b101):
            code = ALU_SRA;
          (f7 == F7_MUL) && (f3 == 3'b000)
            && (MUL_EN != 0):
            code = ALU_MUL;
          default: begin
            code    = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      AOP_ITYPE: begin
        code = base_op(f3);
        if ((f3 == 3'b101) && f7[5])
          code = ALU_SRA;
        if (((f3 == 3'b001) || (f3 == 3'b101))
            && (f7 != F7_BASE) && (f7 != F7_ALT))
          illegal = 1'b1;
      end
      default: code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU: single-cycle ops in one cycle, iterative
// shift-add MUL over XLEN cycles; result held until taken.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MUL_EN = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);

  state_e          state;
  state_e          state_n;
  alu_ctrl_e       dec_code;
  logic            dec_ill;
  logic            accept;
  logic            is_mul;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] res_q;
  alu_ctrl_e       ctrl_q;
  logic            ill_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] acc_n;

  alu_decode #(
    .MUL_EN(MUL_EN)
  ) u_dec (
    .alu_op     (bus.alu_op),
    .ins_for_alu(bus.ins_for_alu),
    .code       (dec_code),
    .illegal    (dec_ill)
  );

  assign bus.in_ready = (state == S_IDLE)
    || ((state == S_DONE) && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign is_mul = (dec_code == ALU_MUL);
  assign sh     = bus.op_b[SHW-1:0];

  assign bus.out_valid   = (state == S_DONE);
  assign bus.result      = res_q;
  assign bus.zero        = (res_q == '0);
  assign bus.alu_control = ctrl_q;
  assign bus.illegal     = ill_q;

  // single-cycle result for the decoded op
  always_comb begin
    alu_y = '0;
    unique case (dec_code)
      ALU_AND:  alu_y = bus.op_a & bus.op_b;
      ALU_OR:   alu_y = bus.op_a | bus.op_b;
      ALU_ADD:  alu_y = bus.op_a + bus.op_b;
      ALU_XOR:  alu_y = bus.op_a ^ bus.op_b;
      ALU_SLL:  alu_y = bus.op_a << sh;
      ALU_SRL:  alu_y = bus.op_a >> sh;
      ALU_SUB:  alu_y = bus.op_a - bus.op_b;
      ALU_SRA:
        alu_y = XLEN'($signed(bus.op_a) >>> sh);
      ALU_SLT:
        alu_y = XLEN'($signed(bus.op_a)
                      < $signed(bus.op_b));
      ALU_SLTU:
        alu_y = XLEN'(bus.op_a < bus.op_b);
      default:  alu_y = '0;
    endcase
  end

  // one shift-add step of the multiplier
  always_comb begin
    acc_n = acc_q;
    if (mplier_q[0])
      acc_n = acc_q + mcand_q;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // next-state selection
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_n = is_mul ? S_MUL_BUSY : S_DONE;
      end
      S_MUL_BUSY: begin
        if (cnt_q == '0)
          state_n = S_DONE;
      end
      S_DONE: begin
        if (accept)
          state_n = is_mul ? S_MUL_BUSY : S_DONE;
        else if (bus.out_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // result registers and multiplier iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      ctrl_q   <= ALU_ADD;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand_q  <= bus.op_a;
        mplier_q <= bus.op_b;
        acc_q    <= '0;
        cnt_q    <= CW'(XLEN - 1);
      end else begin
        res_q  <= alu_y;
        ctrl_q <= dec_code;
        ill_q  <= dec_ill;
      end
    end else if (state == S_MUL_BUSY) begin
      acc_q    <= acc_n;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == '0) begin
        res_q  <= acc_n;
        ctrl_q <= ALU_MUL;
        ill_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule
